// File: rtl/cam_pkg.sv
// cam_pkg: shared window geometry defaults and capture state encoding
package cam_pkg;
  localparam int CAM_H_BYTES = 640;
  localparam int CAM_V_LINES = 200;
  localparam int CAM_ADDR_W = 17;
  localparam int FB_BYTES = CAM_H_BYTES * CAM_V_LINES;
  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2,
    FROZEN  = 2'd3
  } cam_state_e;
endpackage

// File: rtl/cam_edge_det.sv
// cam_edge_det: registers the camera bus once and flags vsync/href edges on the registered copies
module cam_edge_det (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] pdata_i,
  output logic       q_vsync_o,
  output logic       q_href_o,
  output logic [7:0] q_pdata_o,
  output logic       vs_rise_o,
  output logic       vs_fall_o,
  output logic       hr_fall_o
);
  logic       vsync_q, href_q, vsync_p_q, href_p_q;
  logic [7:0] pdata_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      pdata_q   <= 8'd0;
      vsync_p_q <= 1'b0;
      href_p_q  <= 1'b0;
    end else begin
      vsync_q   <= vsync_i;
      href_q    <= href_i;
      pdata_q   <= pdata_i;
      vsync_p_q <= vsync_q;
      href_p_q  <= href_q;
    end
  end
  assign q_vsync_o = vsync_q;
  assign q_href_o  = href_q;
  assign q_pdata_o = pdata_q;
  assign vs_rise_o = vsync_q & ~vsync_p_q;
  assign vs_fall_o = ~vsync_q & vsync_p_q;
  assign hr_fall_o = ~href_q & href_p_q;
endmodule

// File: rtl/cam_frame_capture.sv
// cam_frame_capture: crops the YUYV byte stream to a fixed window and writes it raster-ordered,
// holding the buffer frozen after a complete frame while a freeze is requested
module cam_frame_capture
  import cam_pkg::*;
#(
  parameter int H_BYTES = CAM_H_BYTES,
  parameter int V_LINES = CAM_V_LINES,
  parameter int ADDR_W  = CAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        pdata,
  input  logic              freeze_req,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frozen,
  output logic              short_line,
  output logic              short_frame
);
  localparam logic [9:0]        H_MAX  = 10'(H_BYTES);
  localparam logic [7:0]        V_MAX  = 8'(V_LINES);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_BYTES);
  logic              q_vsync, q_href, vs_rise, vs_fall, hr_fall;
  logic [7:0]        q_pdata;
  cam_state_e        state_q;
  logic [9:0]        col_q;
  logic [7:0]        line_q;
  logic [ADDR_W-1:0] addr_q, wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              wr_en_q, frozen_q, short_line_q, short_frame_q;
  logic              accept_d, line_end_d, short_frame_d;
  cam_edge_det u_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .vsync_i   (vsync),
    .href_i    (href),
    .pdata_i   (pdata),
    .q_vsync_o (q_vsync),
    .q_href_o  (q_href),
    .q_pdata_o (q_pdata),
    .vs_rise_o (vs_rise),
    .vs_fall_o (vs_fall),
    .hr_fall_o (hr_fall)
  );
  // a line ending on the same cycle vsync rises still counts toward the frame
  always_comb begin
    accept_d      = state_q == CAPTURE && q_href && !q_vsync && col_q < H_MAX && line_q < V_MAX;
    line_end_d    = hr_fall && col_q != 10'd0;
    short_frame_d = short_frame_q || (line_q + {7'd0, line_end_d}) < V_MAX;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= WAIT_VS;
      col_q         <= '0;
      line_q        <= '0;
      addr_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frozen_q      <= 1'b0;
      short_line_q  <= 1'b0;
      short_frame_q <= 1'b0;
    end else begin
      wr_en_q <= accept_d;
      if (accept_d) begin
        wr_addr_q <= addr_q;
        wr_data_q <= q_pdata;
        addr_q    <= addr_q + 1'b1;
        col_q     <= col_q + 1'b1;
      end
      case (state_q)
        WAIT_VS: if (q_vsync) state_q <= SYNC;
        SYNC: if (vs_fall) begin
          col_q         <= '0;
          line_q        <= '0;
          addr_q        <= '0;
          short_line_q  <= 1'b0;
          short_frame_q <= 1'b0;
          state_q       <= CAPTURE;
        end
        CAPTURE: begin
          if (hr_fall) begin
            col_q <= '0;
            if (line_end_d) line_q <= line_q + 1'b1;
            // skip the unwritten tail so the next line starts on its raster boundary
            if (line_end_d && col_q < H_MAX) begin
              short_line_q <= 1'b1;
              addr_q       <= addr_q + H_STEP - ADDR_W'(col_q);
            end
          end
          if (vs_rise) begin
            short_frame_q <= short_frame_d;
            if (freeze_req && !short_frame_d) begin
              state_q  <= FROZEN;
              frozen_q <= 1'b1;
            end else state_q <= SYNC;
          end
        end
        FROZEN: if (!freeze_req) begin
          state_q  <= WAIT_VS;
          frozen_q <= 1'b0;
        end
        default: state_q <= WAIT_VS;
      endcase
    end
  end
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frozen      = frozen_q;
  assign short_line  = short_line_q;
  assign short_frame = short_frame_q;
endmodule

// File: tb/tb_cam_frame_capture.sv
// tb_cam_frame_capture: frame-level stimulus with a write scoreboard built from window geometry
module tb_cam_frame_capture;
  localparam int H = 64;
  localparam int V = 12;
  localparam int AW = 17;
  logic          clk = 1'b0;
  logic          reset_n, vsync, href, freeze_req;
  logic [7:0]    pdata, wr_data;
  logic          wr_en, frozen, short_line, short_frame;
  logic [AW-1:0] wr_addr;
  int            errors = 0, checks = 0, nwr = 0, npush = 0;
  logic [AW+7:0] exp_q[$];
  bit            cap, m_fz, m_sl, m_sf;
  typedef struct {
    int nl; int len; int sidx; int slen; bit frz; bit rel;
    int exp_w; bit exp_sl; bit exp_sf; bit exp_fz;
  } row_t;
  row_t rows[9];

  cam_frame_capture #(.H_BYTES(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .vsync       (vsync),
    .href        (href),
    .pdata       (pdata),
    .freeze_req  (freeze_req),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frozen      (frozen),
    .short_line  (short_line),
    .short_frame (short_frame)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got no end of test, required $finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) if (wr_en === 1'b1) begin
    nwr++;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_write: got addr %0d data %0h, required no write", wr_addr, wr_data);
    end else chk("write{addr,data}", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
  end

  task automatic send_line(input int l, input int len, input bit rnd);
    for (int b = 0; b < len; b++) begin
      logic [7:0] d;
      d = rnd ? 8'($urandom_range(0, 255)) : 8'(b);
      href = 1'b1;
      pdata = d;
      if (cap && l < V && b < H) begin
        exp_q.push_back({AW'(l * H + b), d});
        npush++;
      end
      tick(1);
    end
    href = 1'b0;
    pdata = 8'd0;
    tick(4);
  endtask

  task automatic send_frame(input int nl, input int len, input int sidx, input int slen, input bit frz, input bit rnd);
    int ln;
    bit sl = 1'b0;
    nwr = 0;
    npush = 0;
    vsync = 1'b0;
    tick(3);
    for (int l = 0; l < nl; l++) begin
      if (frz && l == nl / 2) freeze_req = 1'b1;
      ln = (l == sidx) ? slen : (rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, H + 6)) : len;
      if (l < V && ln < H) sl = 1'b1;
      send_line(l, ln, rnd);
    end
    vsync = 1'b1;
    tick(4);
    if (cap) begin
      m_sl = sl;
      m_sf = nl < V;
      if (freeze_req && !m_sf) begin
        m_fz = 1'b1;
        cap = 1'b0;
      end
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic release_frz;
    freeze_req = 1'b0;
    tick(4);
    if (m_fz) begin
      m_fz = 1'b0;
      cap = 1'b1;
    end
    chk("frozen_after_release", frozen, 0);
  endtask

  initial begin
    rows[0] = '{12, 64, -1, 0, 1'b0, 1'b0, 768, 1'b0, 1'b0, 1'b0};
    rows[1] = '{14, 70, -1, 0, 1'b0, 1'b0, 768, 1'b0, 1'b0, 1'b0};
    rows[2] = '{12, 64,  5, 60, 1'b0, 1'b0, 764, 1'b1, 1'b0, 1'b0};
    rows[3] = '{ 8, 64, -1, 0, 1'b1, 1'b0, 512, 1'b0, 1'b1, 1'b0};
    rows[4] = '{12, 64, -1, 0, 1'b1, 1'b0, 768, 1'b0, 1'b0, 1'b1};
    rows[5] = '{12, 64, -1, 0, 1'b1, 1'b0,   0, 1'b0, 1'b0, 1'b1};
    rows[6] = '{ 5, 64, -1, 0, 1'b1, 1'b1,   0, 1'b0, 1'b0, 1'b1};
    rows[7] = '{12, 64, -1, 0, 1'b0, 1'b0, 768, 1'b0, 1'b0, 1'b0};
    rows[8] = '{12, 64,  0, 1, 1'b1, 1'b1, 705, 1'b1, 1'b0, 1'b1};
    reset_n = 1'b0;
    vsync = 1'b0;
    href = 1'b0;
    pdata = 8'd0;
    freeze_req = 1'b0;
    cap = 1'b0;
    m_fz = 1'b0;
    m_sl = 1'b0;
    m_sf = 1'b0;
    tick(3);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_frozen", frozen, 0);
    chk("reset_short_line", short_line, 0);
    chk("reset_short_frame", short_frame, 0);
    reset_n = 1'b1;
    vsync = 1'b1;
    tick(4);
    cap = 1'b1;
    vsync = 1'b0;
    tick(3);
    href = 1'b1;
    pdata = 8'hA5;
    exp_q.push_back({AW'(0), 8'hA5});
    tick(1);
    chk("latency_cycle1_wr_en", wr_en, 0);
    pdata = 8'h3C;
    exp_q.push_back({AW'(1), 8'h3C});
    tick(1);
    chk("latency_cycle2_wr_en", wr_en, 1);
    chk("latency_wr_addr", wr_addr, 0);
    chk("latency_wr_data", wr_data, 8'hA5);
    href = 1'b0;
    pdata = 8'd0;
    tick(4);
    for (int l = 1; l < 6; l++) send_line(l, H, 1'b0);
    for (int b = 0; b < 10; b++) begin
      href = 1'b1;
      pdata = 8'(b);
      exp_q.push_back({AW'(6 * H + b), 8'(b)});
      tick(1);
    end
    reset_n = 1'b0;
    tick(1);
    chk("midreset_wr_en", wr_en, 0);
    chk("midreset_wr_addr", wr_addr, 0);
    chk("midreset_wr_data", wr_data, 0);
    chk("midreset_frozen", frozen, 0);
    chk("midreset_short_line", short_line, 0);
    chk("midreset_short_frame", short_frame, 0);
    exp_q.delete();
    cap = 1'b0;
    m_sl = 1'b0;
    tick(1);
    reset_n = 1'b1;
    nwr = 0;
    send_line(0, H, 1'b0);
    send_line(1, H, 1'b0);
    chk("no_write_before_vsync", nwr, 0);
    vsync = 1'b1;
    tick(4);
    cap = 1'b1;
    for (int i = 0; i < 9; i++) begin
      row_t r;
      r = rows[i];
      send_frame(r.nl, r.len, r.sidx, r.slen, r.frz, 1'b0);
      chk($sformatf("row%0d_writes", i), nwr, r.exp_w);
      chk($sformatf("row%0d_short_line", i), short_line, r.exp_sl);
      chk($sformatf("row%0d_short_frame", i), short_frame, r.exp_sf);
      chk($sformatf("row%0d_frozen", i), frozen, r.exp_fz);
      if (r.rel) release_frz();
    end
    for (int i = 0; i < 6; i++) begin
      int nl;
      bit frz;
      nl = $urandom_range(V - 2, V + 2);
      frz = $urandom_range(0, 2) == 0;
      send_frame(nl, H, -1, 0, frz, 1'b1);
      chk($sformatf("rnd%0d_writes", i), nwr, npush);
      chk($sformatf("rnd%0d_short_line", i), short_line, m_sl);
      chk($sformatf("rnd%0d_short_frame", i), short_frame, m_sf);
      chk($sformatf("rnd%0d_frozen", i), frozen, m_fz);
      release_frz();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
